riscv_ctrl_pipe: RTL and testbench

Control pipeline and hazard unit for the 5-stage RV32I core. Takes the decoded control word produced in ID and carries it through the ID/EX, EX/MEM and MEM/WB registers with stall and flush handling. From the in-flight destination registers it generates the load-use stall and the EX-stage forwarding selects. The datapath registers (operands, PC, immediates) live elsewhere and use this block's `o_stall`/`i_flush` semantics.

---
 rtl/riscv_ctrl_pipe_pkg.sv | 79 +++++++
 rtl/riscv_ctrl_pipe_if.sv | 53 +++++
 rtl/riscv_fwd_sel.sv | 30 +++
 rtl/riscv_ctrl_pipe.sv | 82 ++++++++
 tb/tb_riscv_ctrl_pipe.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_ctrl_pipe_pkg.sv
// Shared control encodings and stage-register layouts for the 5-stage RV32I
// control pipeline.
package riscv_ctrl_pipe_pkg;

   localparam logic [1:0] SRC_RD_ALU = 2'b00;
   localparam logic [1:0] SRC_RD_DME = 2'b01;
   localparam logic [1:0] SRC_RD_PC4 = 2'b10;
   localparam logic [1:0] SRC_RD_IMM = 2'b11;

   localparam logic [3:0] ALU_CTRL_ADD  = 4'd0;
   localparam logic [3:0] ALU_CTRL_SUB  = 4'd1;
   localparam logic [3:0] ALU_CTRL_SLL  = 4'd2;
   localparam logic [3:0] ALU_CTRL_SLT  = 4'd3;
   localparam logic [3:0] ALU_CTRL_SLTU = 4'd4;
   localparam logic [3:0] ALU_CTRL_XOR  = 4'd5;
   localparam logic [3:0] ALU_CTRL_SRL  = 4'd6;
   localparam logic [3:0] ALU_CTRL_SRA  = 4'd7;
   localparam logic [3:0] ALU_CTRL_OR   = 4'd8;
   localparam logic [3:0] ALU_CTRL_AND  = 4'd9;

   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

   localparam logic [1:0] FWD_SEL_RF  = 2'b00;
   localparam logic [1:0] FWD_SEL_MEM = 2'b01;
   localparam logic [1:0] FWD_SEL_WB  = 2'b10;

   typedef struct packed {
      logic       valid;
      logic [1:0] src_rd;
      logic       src_alu_a;
      logic       src_alu_b;
      logic       reg_wr_en;
      logic       mem_wr_en;
      logic [3:0] alu_ctrl;
      logic [2:0] funct3;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
   } id_ex_t;

   typedef struct packed {
      logic       valid;
      logic [1:0] src_rd;
      logic       reg_wr_en;
      logic       mem_wr_en;
      logic [2:0] funct3;
      logic [4:0] rd;
   } ex_mem_t;

   typedef struct packed {
      logic       valid;
      logic [1:0] src_rd;
      logic       reg_wr_en;
      logic [4:0] rd;
   } mem_wb_t;

   localparam id_ex_t ID_EX_BUBBLE = '{valid: 1'b0, src_rd: SRC_RD_ALU, src_alu_a: 1'b0,
      src_alu_b: 1'b0, reg_wr_en: 1'b0, mem_wr_en: 1'b0, alu_ctrl: ALU_CTRL_ADD,
      funct3: 3'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0};
   localparam ex_mem_t EX_MEM_BUBBLE = '{valid: 1'b0, src_rd: SRC_RD_ALU, reg_wr_en: 1'b0,
      mem_wr_en: 1'b0, funct3: 3'd0, rd: 5'd0};
   localparam mem_wb_t MEM_WB_BUBBLE = '{valid: 1'b0, src_rd: SRC_RD_ALU, reg_wr_en: 1'b0,
      rd: 5'd0};

   // x0 is hard-wired zero, so a write to it never matches a reader.
   function automatic logic wr_match(input logic valid, input logic wr_en,
                                     input logic [4:0] rd, input logic [4:0] rs);
      return valid & wr_en & (rd != 5'd0) & (rd == rs);
   endfunction

endpackage

// File: rtl/riscv_ctrl_pipe_if.sv
// ID-side control word in, per-stage control and hazard signals out.
interface riscv_ctrl_pipe_if;
   logic       i_id_valid;
   logic [1:0] i_id_src_rd;
   logic       i_id_src_alu_a;
   logic       i_id_src_alu_b;
   logic       i_id_reg_wr_en;
   logic       i_id_mem_wr_en;
   logic [3:0] i_id_alu_ctrl;
   logic [2:0] i_id_funct3;
   logic [4:0] i_id_rs1;
   logic [4:0] i_id_rs2;
   logic [4:0] i_id_rd;
   logic       i_id_rs1_use;
   logic       i_id_rs2_use;
   logic       i_flush;
   logic       o_stall;
   logic       o_ex_src_alu_a;
   logic       o_ex_src_alu_b;
   logic [3:0] o_ex_alu_ctrl;
   logic [2:0] o_ex_funct3;
   logic [4:0] o_ex_rs1;
   logic [4:0] o_ex_rs2;
   logic       o_ex_valid;
   logic       o_mem_mem_wr_en;
   logic [2:0] o_mem_funct3;
   logic [1:0] o_mem_src_rd;
   logic       o_mem_valid;
   logic       o_wb_reg_wr_en;
   logic [1:0] o_wb_src_rd;
   logic [4:0] o_wb_rd;
   logic       o_wb_valid;
   logic [1:0] o_fwd_a;
   logic [1:0] o_fwd_b;

   modport master (
      output i_id_valid, i_id_src_rd, i_id_src_alu_a, i_id_src_alu_b, i_id_reg_wr_en,
             i_id_mem_wr_en, i_id_alu_ctrl, i_id_funct3, i_id_rs1, i_id_rs2, i_id_rd,
             i_id_rs1_use, i_id_rs2_use, i_flush,
      input  o_stall, o_ex_src_alu_a, o_ex_src_alu_b, o_ex_alu_ctrl, o_ex_funct3, o_ex_rs1,
             o_ex_rs2, o_ex_valid, o_mem_mem_wr_en, o_mem_funct3, o_mem_src_rd, o_mem_valid,
             o_wb_reg_wr_en, o_wb_src_rd, o_wb_rd, o_wb_valid, o_fwd_a, o_fwd_b
   );

   modport slave (
      input  i_id_valid, i_id_src_rd, i_id_src_alu_a, i_id_src_alu_b, i_id_reg_wr_en,
             i_id_mem_wr_en, i_id_alu_ctrl, i_id_funct3, i_id_rs1, i_id_rs2, i_id_rd,
             i_id_rs1_use, i_id_rs2_use, i_flush,
      output o_stall, o_ex_src_alu_a, o_ex_src_alu_b, o_ex_alu_ctrl, o_ex_funct3, o_ex_rs1,
             o_ex_rs2, o_ex_valid, o_mem_mem_wr_en, o_mem_funct3, o_mem_src_rd, o_mem_valid,
             o_wb_reg_wr_en, o_wb_src_rd, o_wb_rd, o_wb_valid, o_fwd_a, o_fwd_b
   );
endinterface

// File: rtl/riscv_fwd_sel.sv
// EX operand source select for one register operand; MEM beats WB because
// it holds the younger write.
module riscv_fwd_sel
   import riscv_ctrl_pipe_pkg::*;
#(
   parameter bit FWD_EN = 1'b1
) (
   input  logic [4:0] i_rs,
   input  logic       i_mem_valid,
   input  logic       i_mem_wr_en,
   input  logic [4:0] i_mem_rd,
   input  logic       i_wb_valid,
   input  logic       i_wb_wr_en,
   input  logic [4:0] i_wb_rd,
   output logic [1:0] o_sel
);

   always_comb begin
      // NOTE: o_sel gets its default before any branch so every path assigns it and no latch is inferred.
      o_sel = FWD_SEL_RF;
      if (FWD_EN) begin
         if (wr_match(i_mem_valid, i_mem_wr_en, i_mem_rd, i_rs)) begin
            o_sel = FWD_SEL_MEM;
         end else if (wr_match(i_wb_valid, i_wb_wr_en, i_wb_rd, i_rs)) begin
            o_sel = FWD_SEL_WB;
         end
      end
   end

endmodule

// File: rtl/riscv_ctrl_pipe.sv
// Control pipeline (ID/EX, EX/MEM, MEM/WB) with load-use stall, flush and
// EX-stage forwarding selects.
module riscv_ctrl_pipe
   import riscv_ctrl_pipe_pkg::*;
#(
   parameter bit FWD_EN = 1'b1
) (
   input logic              i_clk,
   input logic              i_rst,
   riscv_ctrl_pipe_if.slave ctrl
);

   id_ex_t     r_ex;
   ex_mem_t    r_mem;
   mem_wb_t    r_wb;
   id_ex_t     w_id;
   logic       w_rs1_ex, w_rs2_ex, w_rs1_mem, w_rs2_mem;
   logic       w_load_use, w_raw, w_stall;
   logic [1:0] w_fwd_a, w_fwd_b;

   assign w_id = '{valid: ctrl.i_id_valid, src_rd: ctrl.i_id_src_rd,
      src_alu_a: ctrl.i_id_src_alu_a, src_alu_b: ctrl.i_id_src_alu_b,
      reg_wr_en: ctrl.i_id_reg_wr_en & ctrl.i_id_valid,
      mem_wr_en: ctrl.i_id_mem_wr_en & ctrl.i_id_valid,
      alu_ctrl: ctrl.i_id_alu_ctrl, funct3: ctrl.i_id_funct3,
      rs1: ctrl.i_id_rs1, rs2: ctrl.i_id_rs2, rd: ctrl.i_id_rd};

   assign w_rs1_ex  = ctrl.i_id_rs1_use & wr_match(r_ex.valid, r_ex.reg_wr_en, r_ex.rd, ctrl.i_id_rs1);
   assign w_rs2_ex  = ctrl.i_id_rs2_use & wr_match(r_ex.valid, r_ex.reg_wr_en, r_ex.rd, ctrl.i_id_rs2);
   assign w_rs1_mem = ctrl.i_id_rs1_use & wr_match(r_mem.valid, r_mem.reg_wr_en, r_mem.rd, ctrl.i_id_rs1);
   assign w_rs2_mem = ctrl.i_id_rs2_use & wr_match(r_mem.valid, r_mem.reg_wr_en, r_mem.rd, ctrl.i_id_rs2);

   // WB is never a hazard source: the register file writes before it is read.
   assign w_load_use = (r_ex.src_rd == SRC_RD_DME) & (w_rs1_ex | w_rs2_ex);
   assign w_raw      = w_rs1_ex | w_rs2_ex | w_rs1_mem | w_rs2_mem;
   assign w_stall    = ctrl.i_id_valid & ~ctrl.i_flush & (FWD_EN ? w_load_use : w_raw);

   // NOTE: sequential state uses non-blocking assignments so all three stages shift on the same edge.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ex  <= ID_EX_BUBBLE;
         r_mem <= EX_MEM_BUBBLE;
         r_wb  <= MEM_WB_BUBBLE;
      end else begin
         r_ex  <= (ctrl.i_flush | w_stall) ? ID_EX_BUBBLE : w_id;
         r_mem <= '{valid: r_ex.valid, src_rd: r_ex.src_rd, reg_wr_en: r_ex.reg_wr_en,
                    mem_wr_en: r_ex.mem_wr_en, funct3: r_ex.funct3, rd: r_ex.rd};
         r_wb  <= '{valid: r_mem.valid, src_rd: r_mem.src_rd, reg_wr_en: r_mem.reg_wr_en,
                    rd: r_mem.rd};
      end
   end

   riscv_fwd_sel #(.FWD_EN(FWD_EN)) u_fwd_a (
      .i_rs(r_ex.rs1), .i_mem_valid(r_mem.valid), .i_mem_wr_en(r_mem.reg_wr_en),
      .i_mem_rd(r_mem.rd), .i_wb_valid(r_wb.valid), .i_wb_wr_en(r_wb.reg_wr_en),
      .i_wb_rd(r_wb.rd), .o_sel(w_fwd_a));

   riscv_fwd_sel #(.FWD_EN(FWD_EN)) u_fwd_b (
      .i_rs(r_ex.rs2), .i_mem_valid(r_mem.valid), .i_mem_wr_en(r_mem.reg_wr_en),
      .i_mem_rd(r_mem.rd), .i_wb_valid(r_wb.valid), .i_wb_wr_en(r_wb.reg_wr_en),
      .i_wb_rd(r_wb.rd), .o_sel(w_fwd_b));

   assign ctrl.o_stall         = w_stall;
   assign ctrl.o_fwd_a         = w_fwd_a;
   assign ctrl.o_fwd_b         = w_fwd_b;
   assign ctrl.o_ex_src_alu_a  = r_ex.src_alu_a;
   assign ctrl.o_ex_src_alu_b  = r_ex.src_alu_b;
   assign ctrl.o_ex_alu_ctrl   = r_ex.alu_ctrl;
   assign ctrl.o_ex_funct3     = r_ex.funct3;
   assign ctrl.o_ex_rs1        = r_ex.rs1;
   assign ctrl.o_ex_rs2        = r_ex.rs2;
   assign ctrl.o_ex_valid      = r_ex.valid;
   assign ctrl.o_mem_mem_wr_en = r_mem.mem_wr_en;
   assign ctrl.o_mem_funct3    = r_mem.funct3;
   assign ctrl.o_mem_src_rd    = r_mem.src_rd;
   assign ctrl.o_mem_valid     = r_mem.valid;
   assign ctrl.o_wb_reg_wr_en  = r_wb.reg_wr_en;
   assign ctrl.o_wb_src_rd     = r_wb.src_rd;
   assign ctrl.o_wb_rd         = r_wb.rd;
   assign ctrl.o_wb_valid      = r_wb.valid;

endmodule

// File: tb/tb_riscv_ctrl_pipe.sv
// Scoreboard bench: expected EX words are queued as each ID word is driven and
// compared as they appear in EX, MEM and WB.
module tb_riscv_ctrl_pipe;
   import riscv_ctrl_pipe_pkg::*;

   typedef struct packed {
      id_ex_t w;
      logic   rs1_use;
      logic   rs2_use;
   } instr_t;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   logic   sel0 = 1'b0;
   int     n_checks = 0;
   int     n_errors = 0;
   id_ex_t q_exp[$];

   logic [19:0] ex_v;
   logic [6:0]  mem_v;
   logic [8:0]  wb_v;
   logic        stall_v;
   logic [1:0]  fa_v, fb_v;

   riscv_ctrl_pipe_if if1();
   riscv_ctrl_pipe_if if0();

   riscv_ctrl_pipe #(.FWD_EN(1'b1)) u_dut1 (.i_clk(clk), .i_rst(rst), .ctrl(if1));
   riscv_ctrl_pipe #(.FWD_EN(1'b0)) u_dut0 (.i_clk(clk), .i_rst(rst), .ctrl(if0));

   always #5 clk = ~clk;

   always_comb begin
      if (sel0) begin
         ex_v    = {if0.o_ex_valid, if0.o_ex_src_alu_a, if0.o_ex_src_alu_b, if0.o_ex_alu_ctrl,
                    if0.o_ex_funct3, if0.o_ex_rs1, if0.o_ex_rs2};
         mem_v   = {if0.o_mem_valid, if0.o_mem_mem_wr_en, if0.o_mem_funct3, if0.o_mem_src_rd};
         wb_v    = {if0.o_wb_valid, if0.o_wb_reg_wr_en, if0.o_wb_src_rd, if0.o_wb_rd};
         stall_v = if0.o_stall;
         fa_v    = if0.o_fwd_a;
         fb_v    = if0.o_fwd_b;
      end else begin
         ex_v    = {if1.o_ex_valid, if1.o_ex_src_alu_a, if1.o_ex_src_alu_b, if1.o_ex_alu_ctrl,
                    if1.o_ex_funct3, if1.o_ex_rs1, if1.o_ex_rs2};
         mem_v   = {if1.o_mem_valid, if1.o_mem_mem_wr_en, if1.o_mem_funct3, if1.o_mem_src_rd};
         wb_v    = {if1.o_wb_valid, if1.o_wb_reg_wr_en, if1.o_wb_src_rd, if1.o_wb_rd};
         stall_v = if1.o_stall;
         fa_v    = if1.o_fwd_a;
         fb_v    = if1.o_fwd_b;
      end
   end

   function automatic logic [19:0] ex_view(input id_ex_t w);
      return {w.valid, w.src_alu_a, w.src_alu_b, w.alu_ctrl, w.funct3, w.rs1, w.rs2};
   endfunction

   function automatic logic [6:0] mem_view(input id_ex_t w);
      return {w.valid, w.mem_wr_en, w.funct3, w.src_rd};
   endfunction

   function automatic logic [8:0] wb_view(input id_ex_t w);
      return {w.valid, w.reg_wr_en, w.src_rd, w.rd};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic instr_t mk(input logic [1:0] src_rd, input logic alu_b, input logic reg_wr,
                                 input logic mem_wr, input logic [3:0] alu, input logic [2:0] f3,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic u1, input logic u2);
      instr_t i;
      i.w = '{valid: 1'b1, src_rd: src_rd, src_alu_a: 1'b0, src_alu_b: alu_b, reg_wr_en: reg_wr,
              mem_wr_en: mem_wr, alu_ctrl: alu, funct3: f3, rs1: rs1, rs2: rs2, rd: rd};
      i.rs1_use = u1;
      i.rs2_use = u2;
      return i;
   endfunction

   function automatic instr_t op_r(input logic [3:0] alu, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2);
      return mk(SRC_RD_ALU, 1'b0, 1'b1, 1'b0, alu, 3'd0, rs1, rs2, rd, 1'b1, 1'b1);
   endfunction

   function automatic instr_t op_addi(input logic [4:0] rd, input logic [4:0] rs1);
      return mk(SRC_RD_ALU, 1'b1, 1'b1, 1'b0, ALU_CTRL_ADD, 3'd0, rs1, 5'd0, rd, 1'b1, 1'b0);
   endfunction

   function automatic instr_t op_lw(input logic [4:0] rd, input logic [4:0] rs1);
      return mk(SRC_RD_DME, 1'b1, 1'b1, 1'b0, ALU_CTRL_ADD, 3'b010, rs1, 5'd0, rd, 1'b1, 1'b0);
   endfunction

   function automatic instr_t op_sw(input logic [4:0] rs2, input logic [4:0] rs1);
      return mk(SRC_RD_ALU, 1'b1, 1'b0, 1'b1, ALU_CTRL_ADD, 3'b010, rs1, rs2, 5'd0, 1'b1, 1'b1);
   endfunction

   // rs1 field carries a stale register number that the instruction never reads.
   function automatic instr_t op_lui(input logic [4:0] rd, input logic [4:0] junk_rs1);
      return mk(SRC_RD_IMM, 1'b1, 1'b1, 1'b0, ALU_CTRL_ADD, 3'd0, junk_rs1, 5'd0, rd, 1'b0, 1'b0);
   endfunction

   function automatic instr_t op_nop();
      instr_t i;
      i.w = ID_EX_BUBBLE;
      i.rs1_use = 1'b0;
      i.rs2_use = 1'b0;
      return i;
   endfunction

   task automatic drive(input instr_t in, input logic flush);
      if1.i_id_valid = in.w.valid;         if0.i_id_valid = in.w.valid;
      if1.i_id_src_rd = in.w.src_rd;       if0.i_id_src_rd = in.w.src_rd;
      if1.i_id_src_alu_a = in.w.src_alu_a; if0.i_id_src_alu_a = in.w.src_alu_a;
      if1.i_id_src_alu_b = in.w.src_alu_b; if0.i_id_src_alu_b = in.w.src_alu_b;
      if1.i_id_reg_wr_en = in.w.reg_wr_en; if0.i_id_reg_wr_en = in.w.reg_wr_en;
      if1.i_id_mem_wr_en = in.w.mem_wr_en; if0.i_id_mem_wr_en = in.w.mem_wr_en;
      if1.i_id_alu_ctrl = in.w.alu_ctrl;   if0.i_id_alu_ctrl = in.w.alu_ctrl;
      if1.i_id_funct3 = in.w.funct3;       if0.i_id_funct3 = in.w.funct3;
      if1.i_id_rs1 = in.w.rs1;             if0.i_id_rs1 = in.w.rs1;
      if1.i_id_rs2 = in.w.rs2;             if0.i_id_rs2 = in.w.rs2;
      if1.i_id_rd = in.w.rd;               if0.i_id_rd = in.w.rd;
      if1.i_id_rs1_use = in.rs1_use;       if0.i_id_rs1_use = in.rs1_use;
      if1.i_id_rs2_use = in.rs2_use;       if0.i_id_rs2_use = in.rs2_use;
      if1.i_flush = flush;                 if0.i_flush = flush;
   endtask

   task automatic check_comb(input string tag, input logic exp_stall,
                             input logic [1:0] efa, input logic [1:0] efb);
      check({tag, "_stall"}, 32'(stall_v), 32'(exp_stall));
      check({tag, "_fwd_a"}, 32'(fa_v), 32'(efa));
      check({tag, "_fwd_b"}, 32'(fb_v), 32'(efb));
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ex"}, 32'(ex_v), 32'(ex_view(ID_EX_BUBBLE)));
      check({tag, "_mem"}, 32'(mem_v), 32'(mem_view(ID_EX_BUBBLE)));
      check({tag, "_wb"}, 32'(wb_v), 32'(wb_view(ID_EX_BUBBLE)));
      check_comb(tag, 1'b0, FWD_SEL_RF, FWD_SEL_RF);
   endtask

   task automatic q_reset();
      q_exp.delete();
      repeat (3) q_exp.push_back(ID_EX_BUBBLE);
   endtask

   // One ID cycle: drive, check combinational outputs, queue the expected EX
   // word, clock, then compare all three stages against the scoreboard.
   task automatic step(input string tag, input instr_t in, input logic flush, input logic exp_stall,
                       input logic [1:0] efa, input logic [1:0] efb);
      id_ex_t e;
      drive(in, flush);
      #1;
      check_comb(tag, exp_stall, efa, efb);
      e = in.w;
      e.reg_wr_en = e.reg_wr_en & e.valid;
      e.mem_wr_en = e.mem_wr_en & e.valid;
      if (flush || exp_stall) e = ID_EX_BUBBLE;
      q_exp.push_back(e);
      @(posedge clk);
      #1;
      check({tag, "_ex"}, 32'(ex_v), 32'(ex_view(q_exp[$])));
      check({tag, "_mem"}, 32'(mem_v), 32'(mem_view(q_exp[$-1])));
      check({tag, "_wb"}, 32'(wb_v), 32'(wb_view(q_exp[$-2])));
      while (q_exp.size() > 3) void'(q_exp.pop_front());
   endtask

   initial begin
      drive(op_nop(), 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check_idle("rst");
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      q_reset();

      // Back-to-back ALU dependences: MEM forward, then WB forward on both operands.
      step("a_add5", op_r(ALU_CTRL_ADD, 5'd5, 5'd1, 5'd2), 1'b0, 1'b0, FWD_SEL_RF, FWD_SEL_RF);
      step("a_sub6", op_r(ALU_CTRL_SUB, 5'd6, 5'd5, 5'd3), 1'b0, 1'b0, FWD_SEL_RF, FWD_SEL_RF);
      step("a_add7", op_r(ALU_CTRL_ADD, 5'd7, 5'd5, 5'd5), 1'b0, 1'b0, FWD_SEL_MEM, FWD_SEL_RF);
      step("a_n1", op_nop(), 1'b0, 1'b0, FWD_SEL_WB, FWD_SEL_WB);
      step("a_n2", op_nop(), 1'b0, 1'b0, FWD_SEL_RF, FWD_SEL_RF);

      // Load-use: one stall cycle, then WB forward on rs1 only.
      step("b_lw5", op_lw(5'd5, 5'd1), 1'b0, 1'b0, FWD_SEL_RF, FWD_SEL_RF);
      step("b_use", op_r(ALU_CTRL_ADD, 5'd6, 5'd5, 5'd0), 1'b0, 1'b1, FWD_SEL_RF, FWD_SEL_RF);
      step("b_retry", op_r(ALU_CTRL_ADD, 5'd6, 5'd5, 5'd0), 1'b0, 1'b0, FWD_SEL_RF, FWD_SEL_RF);
      step("b_n1", op_nop(), 1'b0, 1'b0, FWD_SEL_WB, FWD_SEL_RF);

      // Load to x0 never stalls or forwards.
      step("c_lw0", op_lw(5'd0, 5'd1), 1'b0, 1'b0, FWD_SEL_RF, FWD_SEL_RF);
      step("c_use0", op_r(ALU_CTRL_ADD, 5'd6, 5'd0, 5'd0), 1'b0, 1'b0, FWD_SEL_RF, FWD_SEL_RF);
      step("c_n1", op_nop(), 1'b0, 1'b0, FWD_SEL_RF, FWD_SEL_RF);

      // Load-use coinciding with flush: flush wins, bubble enters EX.
      step("d_lw5", op_lw(5'd5, 5'd1), 1'b0, 1'b0, FWD_SEL_RF, FWD_SEL_RF);
      step("d_flush", op_r(ALU_CTRL_ADD, 5'd6, 5'd5, 5'd1), 1'b1, 1'b0, FWD_SEL_RF, FWD_SEL_RF);
      step("d_sw", op_sw(5'd6, 5'd1), 1'b0, 1'b0, FWD_SEL_RF, FWD_SEL_RF);
      step("d_n1", op_nop(), 1'b0, 1'b0, FWD_SEL_RF, FWD_SEL_RF);

      // Build a pending stall plus MEM forward, then reset asynchronously mid-cycle.
      step("e_add5", op_r(ALU_CTRL_ADD, 5'd5, 5'd1, 5'd2), 1'b0, 1'b0, FWD_SEL_RF, FWD_SEL_RF);
      step("e_lw6", op_lw(5'd6, 5'd5), 1'b0, 1'b0, FWD_SEL_RF, FWD_SEL_RF);
      drive(op_r(ALU_CTRL_ADD, 5'd7, 5'd6, 5'd5), 1'b0);
      #1;
      check_comb("e_pre", 1'b1, FWD_SEL_MEM, FWD_SEL_RF);
      rst = 1'b1;
      #1;
      check_idle("e_async");
      @(posedge clk);
      #1;
      check_idle("e_held");
      @(negedge clk) rst = 1'b0;
      drive(op_nop(), 1'b0);
      @(posedge clk);
      #1;
      q_reset();

      // Forwarding disabled: two stall cycles, selects pinned at register file.
      sel0 = 1'b1;
      step("f_addi5", op_addi(5'd5, 5'd0), 1'b0, 1'b0, FWD_SEL_RF, FWD_SEL_RF);
      step("f_use1", op_r(ALU_CTRL_ADD, 5'd6, 5'd5, 5'd5), 1'b0, 1'b1, FWD_SEL_RF, FWD_SEL_RF);
      step("f_use2", op_r(ALU_CTRL_ADD, 5'd6, 5'd5, 5'd5), 1'b0, 1'b1, FWD_SEL_RF, FWD_SEL_RF);
      step("f_go", op_r(ALU_CTRL_ADD, 5'd6, 5'd5, 5'd5), 1'b0, 1'b0, FWD_SEL_RF, FWD_SEL_RF);
      step("f_addi5b", op_addi(5'd5, 5'd0), 1'b0, 1'b0, FWD_SEL_RF, FWD_SEL_RF);
      step("f_lui", op_lui(5'd9, 5'd5), 1'b0, 1'b0, FWD_SEL_RF, FWD_SEL_RF);
      step("f_n1", op_nop(), 1'b0, 1'b0, FWD_SEL_RF, FWD_SEL_RF);
      step("f_n2", op_nop(), 1'b0, 1'b0, FWD_SEL_RF, FWD_SEL_RF);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
